connection_ctrl: RTL

CONNECTION_CTRL -- requirements
Module: connection_ctrl

---
 rtl/packet_pkg.sv | 19 +
 rtl/conn_port_fsm.sv | 95 +++++++++
 rtl/connection_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/packet_pkg.sv
// Shared definitions for the crossbar connection controller.
//   ADDR_WIDTH   : destination mask width, one bit per crossbar output
//   NUM_IN       : number of crossbar inputs
//   SEL_WIDTH    : width of one crossbar mux select
//   port_state_t : per-input connection state
package packet_pkg;

  localparam int unsigned ADDR_WIDTH = 4;
  localparam int unsigned NUM_IN     = 4;
  localparam int unsigned SEL_WIDTH  = 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    DROP
  } port_state_t;

endpackage

// File: rtl/conn_port_fsm.sv
// Per-input connection FSM (IDLE/REQ/XFER/DROP) with a request wait counter.
//   clk, rst      : clock, synchronous active-high reset
//   in_valid      : head beat valid
//   in_dst        : destination mask of the head beat
//   in_last       : last beat of the packet
//   out_busy      : outputs currently locked by any connection
//   out_ready     : downstream ready per output
//   arb_grant     : this input's grant from the arbiter
//   in_ready      : beat accept for this input
//   arb_req       : request to the arbiter
//   arb_dst       : destination mask presented to the arbiter
//   dst_q         : latched destination mask of the current packet
//   grant_take    : grant accepted this cycle (connection opens next cycle)
//   release_take  : last beat transferred this cycle (connection closes next cycle)
//   starve        : request has waited at least STARVE_LIMIT cycles
module conn_port_fsm
  import packet_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 64,
  parameter int unsigned ADDR_WIDTH   = packet_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_dst,
  input  logic                  in_last,
  input  logic [ADDR_WIDTH-1:0] out_busy,
  input  logic [ADDR_WIDTH-1:0] out_ready,
  input  logic                  arb_grant,
  output logic                  in_ready,
  output logic                  arb_req,
  output logic [ADDR_WIDTH-1:0] arb_dst,
  output logic [ADDR_WIDTH-1:0] dst_q,
  output logic                  grant_take,
  output logic                  release_take,
  output logic                  starve
);

  port_state_t state;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_next;

  // Requests are masked while any wanted output is still locked, so a grant
  // can never land on an output in the same cycle it is being released.
  assign arb_req    = (state == REQ) && ((dst_q & out_busy) == '0);
  assign arb_dst    = arb_req ? dst_q : '0;
  assign grant_take = arb_req & arb_grant;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      XFER:    in_ready = &(out_ready | ~dst_q);
      DROP:    in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign release_take = (state == XFER) && in_valid && in_ready && in_last;

  always_comb begin
    wait_next = '0;
    if (state == REQ && !grant_take)
      wait_next = (wait_cnt == '1) ? wait_cnt : wait_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dst_q    <= '0;
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else begin
      wait_cnt <= wait_next;
      // Derived from the next count so the flag lines up with the counter.
      starve   <= (32'(wait_next) >= STARVE_LIMIT);
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (|in_dst) begin
              dst_q <= in_dst;
              state <= REQ;
            end else begin
              state <= DROP;
            end
          end
        end
        REQ:     if (grant_take) state <= XFER;
        XFER:    if (release_take) state <= IDLE;
        DROP:    if (in_valid && in_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/connection_ctrl.sv
// Crossbar connection controller: four per-input FSMs request outputs from an
// external all-or-nothing arbiter, lock granted outputs and drive the
// registered crossbar mux selects.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_last      : per-input beat valid / last marker
//   in_dst0..3            : per-input head-beat destination mask
//   in_ready              : per-input beat accept
//   arb_reqs, arb_dst0..3 : request vector and masks to the arbiter
//   arb_grant             : grant vector from the arbiter
//   xbar_sel0..3          : per-output mux select (input index)
//   out_active            : per-output locked flag
//   out_ready             : per-output downstream ready
//   starve                : per-input starvation flag
module connection_ctrl
  import packet_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 64,
  parameter int unsigned ADDR_WIDTH   = packet_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_IN-1:0]     in_valid,
  input  logic [ADDR_WIDTH-1:0] in_dst0,
  input  logic [ADDR_WIDTH-1:0] in_dst1,
  input  logic [ADDR_WIDTH-1:0] in_dst2,
  input  logic [ADDR_WIDTH-1:0] in_dst3,
  input  logic [NUM_IN-1:0]     in_last,
  output logic [NUM_IN-1:0]     in_ready,
  output logic [NUM_IN-1:0]     arb_reqs,
  output logic [ADDR_WIDTH-1:0] arb_dst0,
  output logic [ADDR_WIDTH-1:0] arb_dst1,
  output logic [ADDR_WIDTH-1:0] arb_dst2,
  output logic [ADDR_WIDTH-1:0] arb_dst3,
  input  logic [NUM_IN-1:0]     arb_grant,
  output logic [SEL_WIDTH-1:0]  xbar_sel0,
  output logic [SEL_WIDTH-1:0]  xbar_sel1,
  output logic [SEL_WIDTH-1:0]  xbar_sel2,
  output logic [SEL_WIDTH-1:0]  xbar_sel3,
  output logic [ADDR_WIDTH-1:0] out_active,
  input  logic [ADDR_WIDTH-1:0] out_ready,
  output logic [NUM_IN-1:0]     starve
);

  logic [ADDR_WIDTH-1:0] dst_in     [NUM_IN];
  logic [ADDR_WIDTH-1:0] arb_dst_w  [NUM_IN];
  logic [ADDR_WIDTH-1:0] dst_q      [NUM_IN];
  logic [NUM_IN-1:0]     grant_take;
  logic [NUM_IN-1:0]     release_take;
  logic [ADDR_WIDTH-1:0] out_busy;
  logic [ADDR_WIDTH-1:0] grant_mask;
  logic [ADDR_WIDTH-1:0] release_mask;
  logic [SEL_WIDTH-1:0]  xbar_sel   [ADDR_WIDTH];

  assign dst_in[0] = in_dst0;
  assign dst_in[1] = in_dst1;
  assign dst_in[2] = in_dst2;
  assign dst_in[3] = in_dst3;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_port
    conn_port_fsm #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_port (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid[i]),
      .in_dst       (dst_in[i]),
      .in_last      (in_last[i]),
      .out_busy     (out_busy),
      .out_ready    (out_ready),
      .arb_grant    (arb_grant[i]),
      .in_ready     (in_ready[i]),
      .arb_req      (arb_reqs[i]),
      .arb_dst      (arb_dst_w[i]),
      .dst_q        (dst_q[i]),
      .grant_take   (grant_take[i]),
      .release_take (release_take[i]),
      .starve       (starve[i])
    );
  end

  always_comb begin
    grant_mask   = '0;
    release_mask = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (grant_take[i])   grant_mask   = grant_mask   | dst_q[i];
      if (release_take[i]) release_mask = release_mask | dst_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_busy <= '0;
      for (int unsigned n = 0; n < ADDR_WIDTH; n++) xbar_sel[n] <= '0;
    end else begin
      out_busy <= (out_busy & ~release_mask) | grant_mask;
      // Selects only move on a grant; they hold while the output is idle.
      for (int unsigned n = 0; n < ADDR_WIDTH; n++)
        for (int unsigned i = 0; i < NUM_IN; i++)
          if (grant_take[i] && dst_q[i][n]) xbar_sel[n] <= SEL_WIDTH'(i);
    end
  end

  assign out_active = out_busy;
  assign arb_dst0   = arb_dst_w[0];
  assign arb_dst1   = arb_dst_w[1];
  assign arb_dst2   = arb_dst_w[2];
  assign arb_dst3   = arb_dst_w[3];
  assign xbar_sel0  = xbar_sel[0];
  assign xbar_sel1  = xbar_sel[1];
  assign xbar_sel2  = xbar_sel[2];
  assign xbar_sel3  = xbar_sel[3];

endmodule
